// File: rtl/ov7670_config_seq.sv
// ----------------------------------------------------------------------------
// ov7670_config_seq
//
// Walks a registered configuration ROM from address 0 and issues one SCCB
// register write per entry. Two reserved words change the flow:
//   16'hFFFF  end of table  -> stop and raise done (no write issued)
//   16'hFFF0  delay marker  -> pause for DELAY_MS milliseconds, then continue
// Any other word is {reg_addr, reg_value} and becomes one SCCB write.
// The table is at most 256 entries long. After address 8'hFF the sequence
// ends even if no end marker was found, so address 0 is never replayed.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       one-cycle request to run the sequence (honoured in IDLE/DONE)
//   rom_addr    ROM address (8 bits)
//   rom_data    ROM word, valid one cycle after rom_addr changes
//   sccb_ready  SCCB master idle and able to accept a write
//   sccb_start  one-cycle pulse launching a write of sccb_reg/sccb_val
//   sccb_reg    register address of the current write
//   sccb_val    register value of the current write
//   done        sequence finished; held until the next accepted start
// ----------------------------------------------------------------------------
module ov7670_config_seq #(
  parameter int CLK_FREQ_HZ = 25_000_000,
  parameter int DELAY_MS    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  input  logic        sccb_ready,
  output logic        sccb_start,
  output logic [7:0]  sccb_reg,
  output logic [7:0]  sccb_val,
  output logic        done
);

  localparam int DELAY_CYCLES = (CLK_FREQ_HZ / 1000) * DELAY_MS;
  localparam int CNT_RAW      = $clog2(DELAY_CYCLES + 1);
  localparam int CNT_W        = (CNT_RAW < 1) ? 1 : CNT_RAW;
  // Counter runs DELAY_CYCLES-1 .. 0 inclusive, i.e. DELAY_CYCLES cycles.
  localparam logic [CNT_W-1:0] DELAY_LOAD =
    (DELAY_CYCLES > 0) ? CNT_W'(DELAY_CYCLES - 1) : '0;

  localparam logic [15:0] END_MARK   = 16'hFFFF;
  localparam logic [15:0] DELAY_MARK = 16'hFFF0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_SEND,
    S_SETTLE,
    S_WAIT,
    S_DELAY,
    S_DONE
  } state_t;

  state_t           state_q,      state_d;
  logic [7:0]       rom_addr_q,   rom_addr_d;
  logic             sccb_start_q, sccb_start_d;
  logic [7:0]       sccb_reg_q,   sccb_reg_d;
  logic [7:0]       sccb_val_q,   sccb_val_d;
  logic             done_q,       done_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;

  logic last_entry;
  logic delay_expired;

  // The table ends at 8'hFF; there is nothing to advance to past it.
  assign last_entry    = (rom_addr_q == 8'hFF);
  assign delay_expired = (cnt_q == '0);

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rom_addr_q   <= 8'h00;
      sccb_start_q <= 1'b0;
      sccb_reg_q   <= 8'h00;
      sccb_val_q   <= 8'h00;
      done_q       <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      rom_addr_q   <= rom_addr_d;
      sccb_start_q <= sccb_start_d;
      sccb_reg_q   <= sccb_reg_d;
      sccb_val_q   <= sccb_val_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_FETCH;
      end
      // One cycle for the registered ROM to present the new word.
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        // End marker is tested first so it wins over the delay marker.
        if (rom_data == END_MARK)        state_d = S_DONE;
        else if (rom_data == DELAY_MARK) state_d = S_DELAY;
        else                             state_d = S_SEND;
      end
      S_SEND: begin
        if (sccb_ready) state_d = S_SETTLE;
      end
      // Ready is ignored here: the master needs a cycle to see the pulse
      // and drop ready, otherwise WAIT would see a stale ready.
      S_SETTLE: state_d = S_WAIT;
      S_WAIT: begin
        if (sccb_ready) state_d = last_entry ? S_DONE : S_FETCH;
      end
      S_DELAY: begin
        if (delay_expired) state_d = last_entry ? S_DONE : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    rom_addr_d   = rom_addr_q;
    sccb_start_d = 1'b0;
    sccb_reg_d   = sccb_reg_q;
    sccb_val_d   = sccb_val_q;
    done_d       = done_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          done_d     = 1'b0;
          rom_addr_d = 8'h00;
        end
      end
      S_DECODE: begin
        if (rom_data == END_MARK) begin
          done_d = 1'b1;
        end else if (rom_data == DELAY_MARK) begin
          cnt_d = DELAY_LOAD;
        end else begin
          // Held until the next plain entry is decoded.
          sccb_reg_d = rom_data[15:8];
          sccb_val_d = rom_data[7:0];
        end
      end
      S_SEND: begin
        if (sccb_ready) sccb_start_d = 1'b1;
      end
      S_WAIT: begin
        if (sccb_ready) begin
          if (last_entry) done_d     = 1'b1;
          else            rom_addr_d = rom_addr_q + 8'd1;
        end
      end
      S_DELAY: begin
        if (delay_expired) begin
          if (last_entry) done_d     = 1'b1;
          else            rom_addr_d = rom_addr_q + 8'd1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign rom_addr   = rom_addr_q;
  assign sccb_start = sccb_start_q;
  assign sccb_reg   = sccb_reg_q;
  assign sccb_val   = sccb_val_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ov7670_config_seq.sv
// ----------------------------------------------------------------------------
// tb_ov7670_config_seq
//
// Bench for ov7670_config_seq with a 20-cycle delay (10 kHz clock, 2 ms).
// A registered ROM model and a simple SCCB master (ready low for a set number
// of cycles after each write) surround the DUT. Every write is captured at the
// falling edge. Expected write lists, first-write latency and final address
// are derived by walking the ROM contents in a reference model.
// ----------------------------------------------------------------------------
module tb_ov7670_config_seq;

  localparam int CLK_HZ = 10_000;
  localparam int DMS    = 2;
  localparam int DC     = (CLK_HZ / 1000) * DMS;  // delay length in cycles

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        sccb_ready;
  logic        sccb_start;
  logic [7:0]  sccb_reg;
  logic [7:0]  sccb_val;
  logic        done;

  always #5 clk = ~clk;

  ov7670_config_seq #(
    .CLK_FREQ_HZ (CLK_HZ),
    .DELAY_MS    (DMS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .sccb_ready (sccb_ready),
    .sccb_start (sccb_start),
    .sccb_reg   (sccb_reg),
    .sccb_val   (sccb_val),
    .done       (done)
  );

  // Registered ROM model
  logic [15:0] rom_mem [256];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // SCCB master model: ready drops for busy cycles after every write
  int busy_len  = 0;
  int busy_cnt  = 0;
  bit busy_rand = 1'b0;
  always @(posedge clk) begin
    if (sccb_start)
      busy_cnt <= busy_rand ? int'($urandom_range(0, 7)) : busy_len;
    else if (busy_cnt > 0)
      busy_cnt <= busy_cnt - 1;
  end
  assign sccb_ready = (busy_cnt == 0);

  // Cycle counter and write monitor
  int   cyc = 0;
  logic ready_s = 1'b1;
  logic start_prev = 1'b0;
  logic [15:0] cap_q [$];
  int          cap_cyc [$];
  int n_cmp  = 0;
  int n_fail = 0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    ready_s <= sccb_ready;
  end

  always @(negedge clk) begin
    if (sccb_start === 1'b1) begin
      cap_q.push_back({sccb_reg, sccb_val});
      cap_cyc.push_back(cyc);
      n_cmp++;
      if (ready_s !== 1'b1) begin
        n_fail++;
        $display("FAIL launch_ready: write %04h launched with ready=%0b, required 1",
                 {sccb_reg, sccb_val}, ready_s);
      end
      n_cmp++;
      if (start_prev === 1'b1) begin
        n_fail++;
        $display("FAIL pulse_width: sccb_start high 2 cycles in a row, required 1");
      end
    end
    start_prev = sccb_start;
  end

  // Reference model: walk the table and list the writes it should produce
  logic [15:0] exp_q [$];
  int          exp_lat;
  logic [7:0]  exp_addr;
  int          start_cyc;

  task automatic model_run();
    int pend;
    pend     = 0;
    exp_q.delete();
    exp_lat  = -1;
    exp_addr = 8'hFF;
    for (int a = 0; a < 256; a++) begin
      if (rom_mem[a] == 16'hFFFF) begin
        exp_addr = 8'(a);
        break;
      end else if (rom_mem[a] == 16'hFFF0) begin
        pend += 2 + DC;  // fetch + decode + the delay itself
      end else begin
        if (exp_q.size() == 0) exp_lat = 4 + pend;
        exp_q.push_back(rom_mem[a]);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fill_rom(input logic [15:0] v);
    for (int a = 0; a < 256; a++) rom_mem[a] = v;
  endtask

  function automatic logic [15:0] rand_plain();
    logic [15:0] w;
    w = 16'($urandom);
    if (w == 16'hFFFF || w == 16'hFFF0) w = w ^ 16'h0001;
    return w;
  endfunction

  // Launch a new run: wait for an idle master, clear capture, pulse start.
  task automatic pulse_start(input bit fresh);
    int n;
    if (fresh) begin
      n = 0;
      while (sccb_ready !== 1'b1 && n < 200) begin
        @(negedge clk);
        n++;
      end
    end
    @(negedge clk);
    if (fresh) begin
      cap_q.delete();
      cap_cyc.delete();
      start_cyc = cyc;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, " done_reached"}, 32'(done), 32'd1);
    repeat (8) @(negedge clk);  // catch any stray write after done
  endtask

  task automatic compare_model(input string name);
    int lat;
    model_run();
    chk({name, " n_writes"}, 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < cap_q.size()) chk({name, " write_word"}, 32'(cap_q[i]), 32'(exp_q[i]));
    end
    lat = (cap_cyc.size() > 0) ? cap_cyc[0] - start_cyc : -1;
    if (exp_q.size() > 0) chk({name, " first_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, " final_addr"}, 32'(rom_addr), 32'(exp_addr));
    chk({name, " done_sticky"}, 32'(done), 32'd1);
    $display("run %s: writes=%0d expected=%0d lat=%0d addr=%02h", name,
             cap_q.size(), exp_q.size(), lat, rom_addr);
  endtask

  // Table of directed vectors
  typedef struct {
    string            name;
    logic [3:0][15:0] w;      // words at addresses 0..3, rest is 16'hFFFF
    int               busy;
    int               n_wr;
    logic [15:0]      first;
    logic [15:0]      last;
    int               lat;
    logic [7:0]       fin;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [15:0] a0, input logic [15:0] a1,
                              input logic [15:0] a2, input logic [15:0] a3, input int busy,
                              input int nw, input logic [15:0] f, input logic [15:0] l,
                              input int lat, input logic [7:0] fin);
    vec_t v;
    v.name = n; v.w = {a3, a2, a1, a0}; v.busy = busy; v.n_wr = nw;
    v.first = f; v.last = l; v.lat = lat; v.fin = fin;
    return v;
  endfunction

  vec_t vt [7];

  initial begin
    int n;
    int lat;
    int len;
    logic [15:0] act;

    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int lat;
    int len;
    logic [15:0] act;

    vt[0] = mk("basic",        16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF,  0, 1, 16'h1280, 16'h1280,  4, 8'd1);
    vt[1] = mk("delay",        16'hFFF0, 16'h1210, 16'hFFFF, 16'hFFFF,  2, 1, 16'h1210, 16'h1210, 26, 8'd2);
    vt[2] = mk("empty",        16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF,  0, 0, 16'h0000, 16'h0000,  0, 8'd0);
    vt[3] = mk("near_markers", 16'hFFFE, 16'h00FF, 16'hFF0F, 16'hFFFF,  3, 3, 16'hFFFE, 16'hFF0F,  4, 8'd3);
    vt[4] = mk("two_delays",   16'hFFF0, 16'hFFF0, 16'hABCD, 16'hFFFF,  1, 1, 16'hABCD, 16'hABCD, 48, 8'd3);
    vt[5] = mk("backpressure", 16'h1111, 16'h2222, 16'h3333, 16'hFFFF, 50, 3, 16'h1111, 16'h3333,  4, 8'd3);
    vt[6] = mk("four_plain",   16'h0000, 16'h0001, 16'h0002, 16'h0003,  5, 4, 16'h0000, 16'h0003,  4, 8'd4);

    rst_n = 1'b0;
    start = 1'b0;
    fill_rom(16'hFFFF);
    repeat (3) @(negedge clk);
    chk("reset rom_addr",   32'(rom_addr),   32'd0);
    chk("reset sccb_start", 32'(sccb_start), 32'd0);
    chk("reset sccb_reg",   32'(sccb_reg),   32'd0);
    chk("reset sccb_val",   32'(sccb_val),   32'd0);
    chk("reset done",       32'(done),       32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("no_autostart writes", 32'(cap_q.size()), 32'd0);
    chk("no_autostart done",   32'(done),         32'd0);

    // ---- table-driven vectors ----
    for (int i = 0; i < 7; i++) begin
      fill_rom(16'hFFFF);
      for (int a = 0; a < 4; a++) rom_mem[a] = vt[i].w[a];
      busy_len  = vt[i].busy;
      busy_rand = 1'b0;
      pulse_start(1'b1);
      wait_done(vt[i].name, 2000);
      chk({vt[i].name, " n_writes"}, 32'(cap_q.size()), 32'(vt[i].n_wr));
      if (vt[i].n_wr > 0) begin
        act = (cap_q.size() > 0) ? cap_q[0] : 16'hDEAD;
        chk({vt[i].name, " first_write"}, 32'(act), 32'(vt[i].first));
        act = (cap_q.size() > 0) ? cap_q[cap_q.size()-1] : 16'hDEAD;
        chk({vt[i].name, " last_write"}, 32'(act), 32'(vt[i].last));
        lat = (cap_cyc.size() > 0) ? cap_cyc[0] - start_cyc : -1;
        chk({vt[i].name, " latency"}, 32'(lat), 32'(vt[i].lat));
      end
      chk({vt[i].name, " final_addr"}, 32'(rom_addr), 32'(vt[i].fin));
      chk({vt[i].name, " done"}, 32'(done), 32'd1);
      $display("vector %s: writes=%0d addr=%02h done=%0b", vt[i].name, cap_q.size(), rom_addr, done);
    end

    // ---- start ignored mid-run, then restart after done ----
    fill_rom(16'hFFFF);
    for (int a = 0; a < 6; a++) rom_mem[a] = 16'h0100 + 16'(a);
    busy_len = 10;
    pulse_start(1'b1);
    n = 0;
    while (rom_addr !== 8'd3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("midrun reached_addr3", 32'(rom_addr), 32'd3);
    pulse_start(1'b0);
    wait_done("midrun", 2000);
    compare_model("midrun_ignore");
    pulse_start(1'b1);
    chk("restart clears_done", 32'(done), 32'd0);
    wait_done("replay", 2000);
    compare_model("replay");

    // ---- reset during an sccb_start pulse ----
    fill_rom(16'hFFFF);
    for (int a = 0; a < 10; a++) rom_mem[a] = 16'h2000 + 16'(a);
    busy_len = 6;
    pulse_start(1'b1);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(sccb_start === 1'b1 && rom_addr == 8'd2) && n < 500);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_in_pulse sccb_start", 32'(sccb_start), 32'd0);
    chk("rst_in_pulse rom_addr",   32'(rom_addr),   32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- reset while waiting at address 5, then clean rerun ----
    pulse_start(1'b1);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(sccb_start === 1'b1 && rom_addr == 8'd5) && n < 500);
    @(posedge clk);
    #2;
    chk("wait5 addr_before_reset", 32'(rom_addr), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("wait5 rom_addr",   32'(rom_addr),   32'd0);
    chk("wait5 sccb_start", 32'(sccb_start), 32'd0);
    chk("wait5 sccb_reg",   32'(sccb_reg),   32'd0);
    chk("wait5 sccb_val",   32'(sccb_val),   32'd0);
    chk("wait5 done",       32'(done),       32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cap_q.delete();
    cap_cyc.delete();
    repeat (20) @(negedge clk);
    chk("post_reset idle_writes", 32'(cap_q.size()), 32'd0);
    chk("post_reset idle_done",   32'(done),         32'd0);
    pulse_start(1'b1);
    wait_done("after_reset", 2000);
    compare_model("after_reset");

    // ---- 256 plain entries, no end marker ----
    for (int a = 0; a < 256; a++) rom_mem[a] = rand_plain();
    busy_len = 0;
    pulse_start(1'b1);
    wait_done("full_table", 5000);
    repeat (20) @(negedge clk);
    compare_model("full_table");

    // ---- randomized tables against the model ----
    busy_rand = 1'b1;
    for (int it = 0; it < 10; it++) begin
      for (int a = 0; a < 256; a++) rom_mem[a] = 16'($urandom);
      len = int'($urandom_range(1, 12));
      for (int a = 0; a < len; a++)
        rom_mem[a] = ($urandom_range(0, 5) == 0) ? 16'hFFF0 : rand_plain();
      rom_mem[len] = 16'hFFFF;
      pulse_start(1'b1);
      wait_done("random", 3000);
      compare_model("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ov7670_config_seq.md
OV7670_CONFIG_SEQ -- requirements
Module: ov7670_config_seq

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 25_000_000, system clock frequency in Hz.
REQ-002 Parameter DELAY_MS, default 10, length of the delay in ms for each delay marker entry.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to run the configuration sequence.
REQ-006 rom_addr  output  8  address to the configuration ROM.
REQ-007 rom_data  input  16  ROM word {reg_addr[15:8], reg_value[7:0]}; valid 1 cycle after rom_addr changes (registered ROM).
REQ-008 sccb_ready  input  1  SCCB master idle and able to accept a write.
REQ-009 sccb_start  output  1  single-cycle pulse that launches one SCCB register write.
REQ-010 sccb_reg  output  8  register address for the launched write.
REQ-011 sccb_val  output  8  register value for the launched write.
REQ-012 done  output  1  sequence complete; sticky until the next accepted start.

Function
REQ-013 The block SHALL implement the states IDLE, FETCH, DECODE, SEND, SETTLE, WAIT, DELAY and DONE.
REQ-014 In IDLE and DONE, a start=1 SHALL clear done, set rom_addr=0 and go to FETCH.
REQ-015 In any other state, start SHALL be ignored.
REQ-016 FETCH SHALL last exactly 1 cycle to cover the ROM latency, then go to DECODE.
REQ-017 DECODE, rom_data==16'hFFFF: the block SHALL go to DONE and set done=1; no SCCB write is issued.
REQ-018 DECODE, rom_data==16'hFFF0: the block SHALL load the delay counter with DELAY_CYCLES-1 and go to DELAY.
REQ-019 DELAY_CYCLES SHALL equal (CLK_FREQ_HZ/1000)*DELAY_MS, computed at elaboration.
REQ-020 The delay counter SHALL be sized by $clog2(DELAY_CYCLES+1) and SHALL be at least 1 bit wide.
REQ-021 DECODE, any other rom_data value: the block SHALL latch sccb_reg=rom_data[15:8] and sccb_val=rom_data[7:0], then go to SEND.
REQ-022 SEND: when sccb_ready=1, the block SHALL assert sccb_start for exactly 1 cycle and go to SETTLE.
REQ-023 SEND: while sccb_ready=0, the block SHALL hold with sccb_start=0.
REQ-024 SETTLE SHALL last 1 cycle with sccb_ready ignored, giving the master time to drop ready, then go to WAIT.
REQ-025 WAIT: on sccb_ready=1, the block SHALL increment rom_addr and go to FETCH.
REQ-026 DELAY: the counter SHALL decrement each cycle. At 0, the block SHALL increment rom_addr and go to FETCH.
REQ-027 The total time spent in DELAY SHALL be exactly DELAY_CYCLES cycles.
REQ-028 sccb_reg and sccb_val SHALL stay stable from DECODE until the next DECODE that loads new values.
REQ-029 rom_addr at 8'hFF, after a non-end entry: the block SHALL go to DONE without wrapping, so that address 0 is never re-executed.
REQ-030 The end marker SHALL take priority over the delay marker; only exact 16-bit matches count as markers.
REQ-031 Latency from start to the first sccb_start SHALL be 4 cycles (IDLE->FETCH->DECODE->SEND pulse) when sccb_ready=1.

Reset
REQ-032 rst_n=0, at any time including mid-sequence, SHALL immediately force state=IDLE and the outputs to rom_addr=0, sccb_start=0, sccb_reg=0, sccb_val=0, done=0, and clear the delay counter to 0.
REQ-033 After rst_n deasserts, the block SHALL remain in IDLE until a start pulse arrives; there is no automatic start.
REQ-034 Reset asserted during a sccb_start pulse SHALL terminate the pulse asynchronously.

Verification
REQ-035 Run with ROM {0:1280, 1:FFFF}, sccb_ready held at 1, and a start pulse -> one sccb_start with reg=0x12 and val=0x80, 4 cycles after start; done=1 a few cycles later; rom_addr ends at 1.
REQ-036 Run with CLK_FREQ_HZ=10_000, DELAY_MS=2 (DELAY_CYCLES=20) and ROM {0:FFF0, 1:1210, 2:FFFF} -> exactly 20 cycles in DELAY, then a write with reg=0x12 and val=0x10, then done=1.
REQ-037 Backpressure: the master holds sccb_ready=0 for 50 cycles after each start -> sccb_start never fires while ready=0; every entry is sent exactly once, in address order.
REQ-038 Pulse rst_n low while the block is in WAIT at rom_addr=5 -> all outputs read 0 immediately; a new start re-runs the sequence from address 0.
REQ-039 Pulse start while a run is active at address 3 -> no restart and no duplicate writes; a start pulse after done=1 clears done and replays the sequence from address 0.
REQ-040 ROM with no end marker (256 plain entries) -> exactly 256 writes, then done=1, with no wrap to address 0.
